mtime_counter: RTL and testbench

- Free-running 48-bit machine time base with programmable prescaler.
- Drives the mtime bus consumed by the machine timer compare block (mtime_timer).
- Memory-mapped: software can read, write and prescale mtime, and can enable or disable it.
- Reads of the two 32-bit halves are made coherent with a high-half shadow latched on each low-half read.

---
 rtl/mtime_counter_if.sv | 27 ++
 rtl/mtime_counter.sv | 103 ++++++++++
 tb/tb_mtime_counter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mtime_counter_if.sv
// Register bus for mtime_counter: single-cycle read/write strobes, no wait states.
interface mtime_counter_if;
    // mem_we/mem_re are one-cycle strobes qualified by mem_addr; the slave never
    // stalls, writes commit on the strobe's clock edge and mem_rdata is valid
    // combinationally in the same cycle as mem_re (0 when not selected).
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/mtime_counter.sv
// 48-bit machine time base with prescaler and coherent LO/HI readback.
// Optional: define MTIME_DBG_HALT_EN to add a dbg_halt input that freezes counting.
module mtime_counter #(
    parameter logic [31:0] BASE_ADDR      = 32'h4000_2100,
    parameter int          PRESCALE_W     = 16,
    parameter int          RESET_PRESCALE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef MTIME_DBG_HALT_EN
    input  logic           dbg_halt,
`endif
    mtime_counter_if.slave bus,
    output logic [47:0]    mtime,
    output logic           mtime_tick
);
    localparam logic [3:0] OFF_LO   = 4'h0;
    localparam logic [3:0] OFF_HI   = 4'h4;
    localparam logic [3:0] OFF_PRE  = 4'h8;
    localparam logic [3:0] OFF_CTRL = 4'hC;

    logic                  sel;
    logic [3:0]            off;
    logic                  wr_lo;
    logic                  wr_hi;
    logic                  wr_pre;
    logic                  wr_ctrl;
    logic                  rd_lo;
    logic                  halt;
    logic                  en;
    logic [15:0]           hi_shadow;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic                  unused_addr_bits;

    assign sel              = (bus.mem_addr[31:8] == BASE_ADDR[31:8]);
    assign off              = bus.mem_addr[3:0];
    assign unused_addr_bits = ^bus.mem_addr[7:4];

    assign wr_lo   = sel && bus.mem_we && (off == OFF_LO);
    assign wr_hi   = sel && bus.mem_we && (off == OFF_HI);
    assign wr_pre  = sel && bus.mem_we && (off == OFF_PRE);
    assign wr_ctrl = sel && bus.mem_we && (off == OFF_CTRL);
    assign rd_lo   = sel && bus.mem_re && (off == OFF_LO);

`ifdef MTIME_DBG_HALT_EN
    assign halt = dbg_halt;
`else
    assign halt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime      <= '0;
            mtime_tick <= 1'b0;
            pcnt       <= '0;
            prescale   <= PRESCALE_W'(RESET_PRESCALE);
            en         <= 1'b1;
            hi_shadow  <= '0;
        end else begin
            mtime_tick <= 1'b0;
            // A software write to either half suppresses this cycle's increment.
            if (wr_lo || wr_hi) begin
                if (wr_lo) mtime[31:0]  <= bus.mem_wdata;
                if (wr_hi) mtime[47:32] <= bus.mem_wdata[15:0];
                pcnt <= '0;
            end else if (en && !halt) begin
                if (pcnt == prescale) begin
                    pcnt       <= '0;
                    mtime      <= mtime + 48'd1;
                    mtime_tick <= 1'b1;
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
            end else if (!en) begin
                pcnt <= '0;
            end

            // New prescale restarts the phase; the increment already due still lands.
            if (wr_pre) begin
                prescale <= bus.mem_wdata[PRESCALE_W-1:0];
                pcnt     <= '0;
            end
            if (wr_ctrl) en <= bus.mem_wdata[0];

            // Pre-increment high half, so LO-then-HI reads never straddle a carry.
            if (rd_lo) hi_shadow <= mtime[47:32];
        end
    end

    always_comb begin
        bus.mem_rdata = '0;
        if (sel && bus.mem_re) begin
            case (off)
                OFF_LO:   bus.mem_rdata = mtime[31:0];
                OFF_HI:   bus.mem_rdata = {16'h0, hi_shadow};
                OFF_PRE:  bus.mem_rdata = 32'(prescale);
                OFF_CTRL: bus.mem_rdata = {31'h0, en};
                default:  bus.mem_rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mtime_counter.sv
// Self-checking bench for mtime_counter: register table plus scoreboarded count sequences.
module tb_mtime_counter;
    localparam logic [31:0] B = 32'h4000_2100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] mtime;
    logic        mtime_tick;
`ifdef MTIME_DBG_HALT_EN
    logic        dbg_halt;
`endif

    mtime_counter_if bus();

    mtime_counter #(
        .BASE_ADDR     (32'h4000_2100),
        .PRESCALE_W    (16),
        .RESET_PRESCALE(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MTIME_DBG_HALT_EN
        .dbg_halt  (dbg_halt),
`endif
        .bus       (bus),
        .mtime     (mtime),
        .mtime_tick(mtime_tick)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [48:0] exp_q[$];

    typedef struct {
        logic [31:0] wr_addr;
        logic [31:0] wdata;
        logic [31:0] rd_addr;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_we    = 1'b1;
        step();
        bus.mem_we    = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.mem_addr = a;
        bus.mem_re   = 1'b1;
        #1;
        check(name, 64'(bus.mem_rdata), 64'(exp));
        bus.mem_re   = 1'b0;
    endtask

    task automatic push_exp(input logic tick, input logic [47:0] t);
        exp_q.push_back({tick, t});
    endtask

    // Advance one clock per queued expectation and compare {tick, mtime}.
    task automatic run_sb(input string name);
        logic [48:0] e;
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step();
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", name, i), 64'({mtime_tick, mtime}), 64'(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{B + 32'h8,   32'h0000_0003, B + 32'h8,   32'h0000_0003};
        vecs[1] = '{B + 32'h8,   32'hABCD_1234, B + 32'h8,   32'h0000_1234};
        vecs[2] = '{B + 32'hC,   32'hFFFF_FFFE, B + 32'hC,   32'h0000_0000};
        vecs[3] = '{B + 32'hC,   32'hFFFF_FFFF, B + 32'hC,   32'h0000_0001};
        vecs[4] = '{B + 32'h3,   32'h0000_DEAD, B + 32'h3,   32'h0000_0000};
        vecs[5] = '{B + 32'h108, 32'h0000_0077, B + 32'h8,   32'h0000_1234};
        vecs[6] = '{B + 32'h8,   32'h0000_0077, B + 32'h108, 32'h0000_0000};
        vecs[7] = '{B + 32'h8,   32'h0000_0000, B + 32'h8,   32'h0000_0000};

        rst_n         = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
`ifdef MTIME_DBG_HALT_EN
        dbg_halt      = 1'b0;
`endif

        // Reset state, sampled between edges.
        #16;
        check("rst_mtime", 64'({mtime_tick, mtime}), 64'(0));
        bus.mem_addr = B + 32'hC;
        #1;
        check("rdata_idle", 64'(bus.mem_rdata), 64'(0));
        check_read("rst_ctrl", B + 32'hC, 32'h1);
        check_read("rst_pre", B + 32'h8, 32'h0);
        rst_n = 1'b1;

        // PRESCALE=0: first increment on the first edge after release.
        push_exp(1'b1, 48'd1);
        push_exp(1'b1, 48'd2);
        push_exp(1'b1, 48'd3);
        run_sb("count_p0");
        check_read("ctrl_run", B + 32'hC, 32'h1);

        for (int i = 0; i < 8; i++) begin
            bus_write(vecs[i].wr_addr, vecs[i].wdata);
            check_read($sformatf("regvec%0d", i), vecs[i].rd_addr, vecs[i].exp);
        end

        // PRESCALE=3: one increment per 4 clocks.
        bus_write(B, 32'h100);
        bus_write(B + 32'h8, 32'd3);
        check("pre3_wr", 64'({mtime_tick, mtime}), 64'({1'b1, 48'h101}));
        for (int k = 0; k < 12; k++)
            push_exp(((k + 1) % 4) == 0, 48'h101 + 48'((k + 1) / 4));
        run_sb("count_p3");
        check_read("pre3_rb", B + 32'h8, 32'd3);

        // Wrap-around of the full 48-bit value.
        bus_write(B + 32'h8, 32'd0);
        bus_write(B + 32'h4, 32'h0000_FFFF);
        bus_write(B, 32'hFFFF_FFFE);
        check("wrap_set", 64'({mtime_tick, mtime}), 64'({1'b0, 48'hFFFF_FFFF_FFFE}));
        push_exp(1'b1, 48'hFFFF_FFFF_FFFF);
        push_exp(1'b1, 48'h0);
        push_exp(1'b1, 48'h1);
        run_sb("wrap");

        // LO read in the carry cycle, HI read afterwards.
        bus_write(B + 32'h4, 32'h0);
        bus_write(B, 32'hFFFF_FFFF);
        check("coh_set", 64'(mtime), 64'(48'h0000_FFFF_FFFF));
        bus.mem_addr = B;
        bus.mem_re   = 1'b1;
        #1;
        check("coh_lo", 64'(bus.mem_rdata), 64'(32'hFFFF_FFFF));
        @(posedge clk);
        #1;
        bus.mem_re = 1'b0;
        check("coh_live", 64'(mtime), 64'(48'h1_0000_0000));
        check_read("coh_hi", B + 32'h4, 32'h0);

        // Read and write of the same register in one cycle.
        bus.mem_addr  = B + 32'h8;
        bus.mem_wdata = 32'd7;
        bus.mem_we    = 1'b1;
        bus.mem_re    = 1'b1;
        #1;
        check("same_rw_old", 64'(bus.mem_rdata), 64'(0));
        @(posedge clk);
        #1;
        bus.mem_we = 1'b0;
        bus.mem_re = 1'b0;
        check_read("same_rw_new", B + 32'h8, 32'd7);
        bus_write(B + 32'h8, 32'd0);

        // Disable: write cycle still counts, then frozen for 20 clocks.
        bus_write(B + 32'h4, 32'h0);
        bus_write(B, 32'h50);
        bus_write(B + 32'hC, 32'h0);
        check("en_off_wr", 64'({mtime_tick, mtime}), 64'({1'b1, 48'h51}));
        for (int k = 0; k < 20; k++) push_exp(1'b0, 48'h51);
        run_sb("frozen");
        check_read("en_rb", B + 32'hC, 32'h0);
        bus_write(B + 32'hC, 32'h1);
        check("en_on_wr", 64'({mtime_tick, mtime}), 64'({1'b0, 48'h51}));
        push_exp(1'b1, 48'h52);
        push_exp(1'b1, 48'h53);
        run_sb("reenable");

        // LO write while counting: no increment in the write cycle.
        bus_write(B, 32'h1234);
        check("lo_wr", 64'({mtime_tick, mtime}), 64'({1'b0, 48'h1234}));
        push_exp(1'b1, 48'h1235);
        push_exp(1'b1, 48'h1236);
        run_sb("after_lo_wr");

`ifdef MTIME_DBG_HALT_EN
        // Halt at pcnt=2 with PRESCALE=5; resume from the held phase.
        bus_write(B + 32'h8, 32'd5);
        bus_write(B, 32'h0);
        push_exp(1'b0, 48'h0);
        push_exp(1'b0, 48'h0);
        run_sb("halt_pre");
        dbg_halt = 1'b1;
        for (int k = 0; k < 10; k++) push_exp(1'b0, 48'h0);
        run_sb("halted");
        dbg_halt = 1'b0;
        push_exp(1'b0, 48'h0);
        push_exp(1'b0, 48'h0);
        push_exp(1'b0, 48'h0);
        push_exp(1'b1, 48'h1);
        run_sb("halt_release");
        bus_write(B + 32'h8, 32'd0);
`endif

        // Asynchronous reset while ticking.
        bus_write(B, 32'h77);
        step();
        check("rst_mid_pre", 64'({mtime_tick, mtime}), 64'({1'b1, 48'h78}));
        rst_n = 1'b0;
        #1;
        check("rst_mid", 64'({mtime_tick, mtime}), 64'(0));
        check_read("rst_mid_ctrl", B + 32'hC, 32'h1);
        rst_n = 1'b1;
        push_exp(1'b1, 48'h1);
        run_sb("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
